// File: rtl/dmrw_unit.sv
// dmrw_unit: data-memory read/write stage for RV32I loads and stores
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   cpu_stat_dmrw          sequencer is in the DMRW state
//   is_load, is_store      current instruction class
//   ldst_funct3            RV32I size/sign code of the access
//   ls_addr, st_data       effective byte address and store source value
//   dmrw_run               access in progress, sequencer holds DMRW while high
//   dm_req/dm_we/dm_addr/dm_be/dm_wdata, dm_ack/dm_rdata
//                          single-port data memory req/ack interface
//   ld_data, ld_valid      registered, extended load result and its write-back pulse
//   misalign_err           pulse for a misaligned or illegal access (no memory access made)
module dmrw_unit #(
   parameter int DM_ADDR_W = 12
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 cpu_stat_dmrw,
   input  logic                 is_load,
   input  logic                 is_store,
   input  logic [2:0]           ldst_funct3,
   input  logic [31:0]          ls_addr,
   input  logic [31:0]          st_data,
   output logic                 dmrw_run,
   output logic                 dm_req,
   output logic                 dm_we,
   output logic [DM_ADDR_W-1:0] dm_addr,
   output logic [3:0]           dm_be,
   output logic [31:0]          dm_wdata,
   input  logic                 dm_ack,
   input  logic [31:0]          dm_rdata,
   output logic [31:0]          ld_data,
   output logic                 ld_valid,
   output logic                 misalign_err
);
   typedef enum logic [1:0] {D_IDLE, D_WAIT, D_DONE} state_t;
   state_t state, state_nx;
   logic mem_op, legal, aligned, start, fault, acc, in_wait;
   logic [3:0] be_live;
   logic [31:0] wdata_live, rshift, ld_ext;
   logic [2:0] cur_f3;
   logic [1:0] cur_off;
   logic r_we;
   logic [DM_ADDR_W-1:0] r_addr;
   logic [3:0] r_be;
   logic [31:0] r_wdata;
   logic [2:0] r_f3;
   logic [1:0] r_off;
   logic unused_hi;
   assign unused_hi = ^ls_addr[31:DM_ADDR_W+2];
   always_comb begin
      mem_op = cpu_stat_dmrw & (is_load | is_store);
      legal = is_store ? (ldst_funct3 < 3'd3) : (ldst_funct3[1:0] != 2'b11 && ldst_funct3 != 3'd6);
      aligned = ldst_funct3[1:0] == 2'd0 ? 1'b1 : ldst_funct3[1:0] == 2'd1 ? ~ls_addr[0] : ls_addr[1:0] == 2'b00;
      // gating with rst_n keeps the bus quiet while reset is held, even with live request inputs
      start = rst_n & mem_op & (state == D_IDLE) & legal & aligned;
      fault = mem_op & (state == D_IDLE) & ~(legal & aligned);
      in_wait = state == D_WAIT;
      be_live = ldst_funct3[1:0] == 2'd0 ? 4'b0001 << ls_addr[1:0] :
                ldst_funct3[1:0] == 2'd1 ? (ls_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
      wdata_live = ~is_store ? 32'd0 :
                   ldst_funct3[1:0] == 2'd0 ? {4{st_data[7:0]}} :
                   ldst_funct3[1:0] == 2'd1 ? {2{st_data[15:0]}} : st_data;
      // the first request cycle is driven from live inputs, later cycles from latched fields
      dm_req = start | in_wait;
      dmrw_run = dm_req;
      dm_we = in_wait ? r_we : is_store;
      dm_addr = in_wait ? r_addr : ls_addr[DM_ADDR_W+1:2];
      dm_be = in_wait ? r_be : be_live;
      dm_wdata = in_wait ? r_wdata : wdata_live;
      cur_f3 = in_wait ? r_f3 : ldst_funct3;
      cur_off = in_wait ? r_off : ls_addr[1:0];
      acc = dm_req & dm_ack & ~dm_we;
      rshift = dm_rdata >> {cur_off, 3'b000};
      ld_ext = cur_f3 == 3'd0 ? {{24{rshift[7]}}, rshift[7:0]} :
               cur_f3 == 3'd4 ? {24'd0, rshift[7:0]} :
               cur_f3 == 3'd1 ? {{16{rshift[15]}}, rshift[15:0]} :
               cur_f3 == 3'd5 ? {16'd0, rshift[15:0]} : rshift;
      state_nx = in_wait ? (dm_ack ? D_DONE : D_WAIT) :
                 state == D_DONE ? D_IDLE :
                 start ? (dm_ack ? D_DONE : D_WAIT) : D_IDLE;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= D_IDLE;
         ld_data <= 32'd0;
         ld_valid <= 1'b0;
         misalign_err <= 1'b0;
         r_we <= 1'b0;
         r_addr <= '0;
         r_be <= 4'd0;
         r_wdata <= 32'd0;
         r_f3 <= 3'd0;
         r_off <= 2'd0;
      end else begin
         state <= state_nx;
         ld_valid <= acc;
         misalign_err <= fault;
         if (start) begin
            r_we <= is_store;
            r_addr <= ls_addr[DM_ADDR_W+1:2];
            r_be <= be_live;
            r_wdata <= wdata_live;
            r_f3 <= ldst_funct3;
            r_off <= ls_addr[1:0];
         end
         if (acc) ld_data <= ld_ext;
      end
   end
endmodule

// File: tb/tb_dmrw_unit.sv
// tb_dmrw_unit: randomized self-checking bench for dmrw_unit against an arithmetic reference model
module tb_dmrw_unit;
   logic clk = 0, rst_n = 0, cpu_stat_dmrw = 0, is_load = 0, is_store = 0, dm_ack = 0;
   logic [2:0] ldst_funct3 = 0;
   logic [31:0] ls_addr = 0, st_data = 0, dm_rdata = 0;
   logic dmrw_run, dm_req, dm_we, ld_valid, misalign_err;
   logic [11:0] dm_addr;
   logic [3:0] dm_be;
   logic [31:0] dm_wdata, ld_data;
   int total = 0, bad = 0;
   logic [31:0] exp_ld = 0;

   dmrw_unit #(.DM_ADDR_W(12)) dut (
      .clk(clk), .rst_n(rst_n), .cpu_stat_dmrw(cpu_stat_dmrw), .is_load(is_load),
      .is_store(is_store), .ldst_funct3(ldst_funct3), .ls_addr(ls_addr), .st_data(st_data),
      .dmrw_run(dmrw_run), .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be),
      .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata), .ld_data(ld_data),
      .ld_valid(ld_valid), .misalign_err(misalign_err));

   always #5 clk = ~clk;

   function automatic bit m_legal(bit ld, logic [2:0] f3);
      return ld ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 inside {3'd0, 3'd1, 3'd2});
   endfunction

   function automatic logic [3:0] m_be(logic [2:0] f3, logic [1:0] off);
      int n;
      n = 1 << f3[1:0];
      return 4'(((1 << n) - 1) << off);
   endfunction

   function automatic logic [31:0] m_wd(logic [2:0] f3, logic [31:0] sd);
      if (f3[1:0] == 2'd0) return {24'd0, sd[7:0]} * 32'h01010101;
      if (f3[1:0] == 2'd1) return {16'd0, sd[15:0]} * 32'h00010001;
      return sd;
   endfunction

   function automatic logic [31:0] m_ld(logic [2:0] f3, logic [1:0] off, logic [31:0] rd);
      logic [63:0] v;
      int bits;
      bits = 8 << f3[1:0];
      v = {32'd0, rd} >> (8 * off);
      if (bits < 32) begin
         v = v % (64'd1 << bits);
         if (!f3[2] && v >= (64'd1 << (bits - 1))) v = v - (64'd1 << bits);
      end
      return v[31:0];
   endfunction

   task automatic run_op(input bit ld, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] sd, input logic [31:0] rd, input int nwait);
      bit ok;
      logic [3:0] ebe;
      logic [31:0] ewd;
      ok = m_legal(ld, f3) && (a % (32'd1 << f3[1:0])) == 0;
      ebe = m_be(f3, a[1:0]);
      ewd = ld ? 32'd0 : m_wd(f3, sd);
      @(negedge clk);
      cpu_stat_dmrw = 1; is_load = ld; is_store = !ld; ldst_funct3 = f3;
      ls_addr = a; st_data = sd; dm_ack = (nwait == 0); dm_rdata = (nwait == 0) ? rd : $urandom;
      #1;
      if (!ok) begin
         total++;
         if (dm_req !== 1'b0 || dmrw_run !== 1'b0) begin
            bad++; $display("FAIL fault_noreq: dm_req=%b dmrw_run=%b want 0 0 (ld=%0d f3=%0d a=%h)", dm_req, dmrw_run, ld, f3, a);
         end
         @(negedge clk);
         cpu_stat_dmrw = 0; is_load = 0; is_store = 0; dm_ack = 0;
         #1;
         total++;
         if (misalign_err !== 1'b1 || ld_valid !== 1'b0) begin
            bad++; $display("FAIL fault_pulse: misalign_err=%b ld_valid=%b want 1 0", misalign_err, ld_valid);
         end
         total++;
         if (ld_data !== exp_ld) begin
            bad++; $display("FAIL fault_ld_hold: ld_data=%h want %h", ld_data, exp_ld);
         end
         @(negedge clk);
         #1;
         total++;
         if (misalign_err !== 1'b0) begin
            bad++; $display("FAIL fault_one_cycle: misalign_err=%b want 0", misalign_err);
         end
         return;
      end
      for (int c = 0; c <= nwait; c++) begin
         total++;
         if (dm_req !== 1'b1 || dmrw_run !== 1'b1 || dm_we !== (ld ? 1'b0 : 1'b1) ||
             dm_addr !== 12'(a >> 2) || dm_be !== ebe || dm_wdata !== ewd || misalign_err !== 1'b0) begin
            bad++;
            $display("FAIL req_cycle%0d: req=%b run=%b we=%b addr=%h be=%b wdata=%h err=%b want 1 1 %b %h %b %h 0",
                     c, dm_req, dmrw_run, dm_we, dm_addr, dm_be, dm_wdata, misalign_err, !ld, 12'(a >> 2), ebe, ewd);
         end
         @(negedge clk);
         if (c < nwait) begin
            dm_ack = (c + 1 == nwait);
            dm_rdata = dm_ack ? rd : $urandom;
            ls_addr = $urandom;
            st_data = $urandom;
         end else begin
            dm_ack = 0;
            dm_rdata = $urandom;
         end
         #1;
      end
      if (ld) exp_ld = m_ld(f3, a[1:0], rd);
      total++;
      if (dm_req !== 1'b0 || dmrw_run !== 1'b0 || ld_valid !== ld || misalign_err !== 1'b0) begin
         bad++;
         $display("FAIL done_cycle: req=%b run=%b ld_valid=%b err=%b want 0 0 %b 0", dm_req, dmrw_run, ld_valid, misalign_err, ld);
      end
      total++;
      if (ld_data !== exp_ld) begin
         bad++; $display("FAIL ld_data: got %h want %h (f3=%0d a=%h rd=%h)", ld_data, exp_ld, f3, a, rd);
      end
      @(negedge clk);
      cpu_stat_dmrw = 0; is_load = 0; is_store = 0;
      #1;
      total++;
      if (ld_valid !== 1'b0 || dm_req !== 1'b0) begin
         bad++; $display("FAIL after_done: ld_valid=%b dm_req=%b want 0 0", ld_valid, dm_req);
      end
   endtask

   task automatic test_reset;
      rst_n = 0; cpu_stat_dmrw = 1; is_load = 1; ldst_funct3 = 3'd2; ls_addr = 32'h100; dm_ack = 1;
      #12;
      total++;
      if (dm_req !== 1'b0 || dmrw_run !== 1'b0 || ld_valid !== 1'b0 || misalign_err !== 1'b0 || ld_data !== 32'd0) begin
         bad++;
         $display("FAIL reset: req=%b run=%b ld_valid=%b err=%b ld_data=%h want 0 0 0 0 0", dm_req, dmrw_run, ld_valid, misalign_err, ld_data);
      end
      cpu_stat_dmrw = 0; is_load = 0; dm_ack = 0;
      @(negedge clk);
      rst_n = 1;
   endtask

   task automatic test_lw;
      run_op(1, 3'd2, 32'h100, 32'h0, 32'hDEADBEEF, 0);
   endtask

   task automatic test_loads;
      run_op(1, 3'd0, 32'h203, 32'h0, 32'h80FF1234, 0);
      run_op(1, 3'd4, 32'h203, 32'h0, 32'h80FF1234, 1);
      run_op(1, 3'd5, 32'h202, 32'h0, 32'h80FF1234, 2);
      run_op(1, 3'd1, 32'h202, 32'h0, 32'h80FF1234, 0);
   endtask

   task automatic test_store_wait;
      run_op(0, 3'd1, 32'h006, 32'h1234ABCD, 32'h0, 3);
      run_op(0, 3'd0, 32'h00D, 32'h000000A5, 32'h0, 1);
      run_op(0, 3'd2, 32'h7FC, 32'hCAFEF00D, 32'h0, 0);
   endtask

   task automatic test_misalign;
      run_op(1, 3'd2, 32'h102, 32'h0, 32'h11111111, 0);
      run_op(1, 3'd3, 32'h100, 32'h0, 32'h22222222, 0);
      run_op(0, 3'd1, 32'h101, 32'h55AA, 32'h0, 0);
      run_op(0, 3'd4, 32'h100, 32'h55AA, 32'h0, 0);
   endtask

   task automatic test_non_mem;
      @(negedge clk);
      cpu_stat_dmrw = 1; is_load = 0; is_store = 0; ldst_funct3 = 3'd3; ls_addr = 32'h103;
      #1;
      total++;
      if (dm_req !== 1'b0 || dmrw_run !== 1'b0) begin
         bad++; $display("FAIL non_mem: dm_req=%b dmrw_run=%b want 0 0", dm_req, dmrw_run);
      end
      @(negedge clk);
      cpu_stat_dmrw = 0;
      #1;
      total++;
      if (misalign_err !== 1'b0 || ld_valid !== 1'b0) begin
         bad++; $display("FAIL non_mem_pulse: misalign_err=%b ld_valid=%b want 0 0", misalign_err, ld_valid);
      end
   endtask

   task automatic test_reset_abort;
      @(negedge clk);
      cpu_stat_dmrw = 1; is_store = 1; ldst_funct3 = 3'd2; ls_addr = 32'h40; st_data = 32'h12345678; dm_ack = 0;
      @(negedge clk);
      #1;
      total++;
      if (dm_req !== 1'b1 || dmrw_run !== 1'b1) begin
         bad++; $display("FAIL abort_wait: dm_req=%b dmrw_run=%b want 1 1", dm_req, dmrw_run);
      end
      #2 rst_n = 0;
      #1;
      exp_ld = 32'd0;
      total++;
      if (dm_req !== 1'b0 || dmrw_run !== 1'b0 || ld_data !== 32'd0) begin
         bad++; $display("FAIL abort_async: dm_req=%b dmrw_run=%b ld_data=%h want 0 0 0", dm_req, dmrw_run, ld_data);
      end
      cpu_stat_dmrw = 0; is_store = 0;
      @(negedge clk);
      rst_n = 1;
      run_op(1, 3'd2, 32'h44, 32'h0, 32'h0BADF00D, 1);
   endtask

   task automatic test_random;
      for (int i = 0; i < 60; i++) begin
         bit ld;
         logic [2:0] f3;
         logic [31:0] a;
         ld = 1'($urandom % 2);
         f3 = 3'($urandom % 8);
         a = $urandom;
         if ($urandom % 4 != 0) a = a & ~((32'd1 << f3[1:0]) - 1);
         run_op(ld, f3, a, $urandom, $urandom, int'($urandom % 4));
      end
   endtask

   initial begin
      test_reset;
      test_lw;
      test_loads;
      test_store_wait;
      test_misalign;
      test_non_mem;
      test_reset_abort;
      test_random;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/dmrw_unit.md
Name: dmrw_unit

Overview:
- Data-memory read/write stage, directly downstream of the CPU sequencer.
- Active while the sequencer reports the DMRW state (cpu_stat_dmrw=1). Performs the RV32I load or store on a single-port 32-bit data memory using a req/ack handshake.
- Drives dmrw_run back to the sequencer, which holds the DMRW state until the access completes.
- Delivers an aligned, sign- or zero-extended load result to write-back.

Parameters:
DM_ADDR_W, 12, word-address width of data memory (byte address bits [DM_ADDR_W+1:2] used)

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
cpu_stat_dmrw  input  1  sequencer is in DMRW state
is_load  input  1  current instruction is a load (stable while cpu_stat_dmrw=1)
is_store  input  1  current instruction is a store
ldst_funct3  input  3  RV32I funct3 (LB 0, LH 1, LW 2, LBU 4, LHU 5; SB 0, SH 1, SW 2)
ls_addr  input  32  effective byte address from EX
st_data  input  32  store source register value
dmrw_run  output  1  access in progress; sequencer stays in DMRW while 1
dm_req  output  1  memory request
dm_we  output  1  1 = write, 0 = read
dm_addr  output  DM_ADDR_W  word address
dm_be  output  4  byte enables
dm_wdata  output  32  write data, lane-replicated
dm_ack  input  1  memory accepts/completes request in this cycle
dm_rdata  input  32  read data, valid when dm_req & dm_ack & ~dm_we
ld_data  output  32  extended load result (registered)
ld_valid  output  1  one-cycle pulse: ld_data updated, write back
misalign_err  output  1  one-cycle pulse: misaligned or illegal funct3 access, no memory access made

Behaviour:
- Reset: state=D_IDLE; ld_data=0, ld_valid=0, misalign_err=0, all latched request fields 0. dm_req=0, dmrw_run=0.
- start = cpu_stat_dmrw & (is_load|is_store) & state==D_IDLE & legal & aligned.
- legal: funct3 in {0,1,2,4,5} for loads; {0,1,2} for stores.
- aligned: half requires ls_addr[0]=0; word requires ls_addr[1:0]=0.
- States:
  - D_IDLE:
    - If start: dm_req=1 combinationally from live inputs; latch we/addr/be/wdata/funct3/addr[1:0].
    - If start & dm_ack: go D_DONE. Else if start: go D_WAIT.
    - If cpu_stat_dmrw & mem op & ~(legal&aligned): misalign_err=1 next cycle, stay D_IDLE, no dm_req.
  - D_WAIT: dm_req=1 from latched fields (address/data/be stable until ack). On dm_ack go D_DONE.
  - D_DONE: dm_req=0; unconditionally go D_IDLE.
- dmrw_run = start | (state==D_WAIT). It is low in D_DONE, so the sequencer leaves DMRW one cycle after ack. dmrw_run is 0 for non-memory instructions and for faulting accesses (DMRW lasts 1 cycle).
- A memory op therefore occupies DMRW for 2 + (number of cycles dm_ack is low after request) cycles.
- A request is never withdrawn before ack, even if cpu_stat_dmrw drops. Only rst_n aborts: reset mid-D_WAIT returns to D_IDLE with dm_req=0 immediately (asynchronous).
- dm_addr = addr[DM_ADDR_W+1:2]. dm_we = is_store.
- Stores:
  - SB: be = 4'b0001 << addr[1:0], wdata = {4{st_data[7:0]}}.
  - SH: be = addr[1] ? 4'b1100 : 4'b0011, wdata = {2{st_data[15:0]}}.
  - SW: be = 4'b1111, wdata = st_data.
- Loads:
  - dm_be uses the same size-based pattern as stores; dm_wdata = 0.
  - On the ack cycle, register ld_data = extend(dm_rdata >> (8*addr[1:0])).
  - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW unchanged.
- ld_valid=1 during the D_DONE cycle only, and only for loads. ld_data holds until the next load completes; it is unchanged by stores and faults.
- misalign_err and ld_valid are never high together. Back-to-back instructions are separated by at least the sequencer's PC..EX states, so no overlap with D_DONE.

Test Plan:
1. LW ls_addr=0x100, dm_ack=1 in request cycle, dm_rdata=0xDEADBEEF -> dm_addr=0x040, be=1111, dmrw_run high 1 cycle, next cycle ld_valid=1, ld_data=0xDEADBEEF, dmrw_run=0.
2. LB ls_addr=0x203, dm_rdata=0x80FF1234 -> be=1000, ld_data=0xFFFFFF80. LBU same -> 0x00000080. LHU addr 0x202 -> 0x000080FF.
3. SH ls_addr=0x006, st_data=0x1234ABCD, ack after 3 wait cycles -> dm_req, dm_we=1, be=1100, wdata=0xABCDABCD stable for 4 cycles; dmrw_run high 4 cycles; no ld_valid.
4. LW ls_addr=0x102 -> no dm_req, dmrw_run=0, misalign_err pulse 1 cycle later, ld_data unchanged. Repeat with load funct3=3 -> same.
5. cpu_stat_dmrw=1 with is_load=is_store=0 -> dmrw_run=0, dm_req=0, no pulses.
6. SW in D_WAIT (ack withheld), assert rst_n=0 -> dm_req=0, dmrw_run=0 asynchronously. After release, a new LW completes normally.
